// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect NUM_BTN push-buttons and derive a one-hot speed select.
// Build option: define STICKY_SELECT_EN to latch the last pressed button instead of following levels.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LO, RISE, HI, FALL} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_level, r_press;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_state <= LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == HI) || (w_state_nxt == FALL);
            r_press <= (r_state == RISE) && (w_state_nxt == HI);
        end
    end

    // The counter stops at CNT_MAX because reaching it always leaves the qualifying state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LO: if (w_s) begin
                w_state_nxt = RISE;
                w_cnt_nxt   = '0;
            end
            RISE: begin
                if (!w_s) begin
                    w_state_nxt = LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HI: if (!w_s) begin
                w_state_nxt = FALL;
                w_cnt_nxt   = '0;
            end
            FALL: begin
                if (w_s) begin
                    w_state_nxt = HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = LO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_press = r_press;
endmodule

module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] speed_sel
);
    logic [NUM_BTN-1:0] w_level, w_press, w_sel_nxt;
    logic [NUM_BTN-1:0] r_sel;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );
    end

`ifdef STICKY_SELECT_EN
    localparam logic [NUM_BTN-1:0] SEL_RST = NUM_BTN'(1);

    // x & -x isolates the lowest set bit, so simultaneous presses resolve to the lowest index.
    always_comb begin
        w_sel_nxt = r_sel;
        if (|w_press)
            w_sel_nxt = w_press & (~w_press + NUM_BTN'(1));
    end
`else
    localparam logic [NUM_BTN-1:0] SEL_RST = '0;

    // Zero or several held buttons map to 0, the slowest speed downstream.
    always_comb begin
        w_sel_nxt = '0;
        if ((w_level != '0) && ((w_level & (w_level - NUM_BTN'(1))) == '0))
            w_sel_nxt = w_level;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sel <= SEL_RST;
        else        r_sel <= w_sel_nxt;
    end

    assign btn_level = w_level;
    assign btn_press = w_press;
    assign speed_sel = r_sel;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
module tb_button_conditioner;
    localparam int NB = 5;
    localparam int DB = 8;
    localparam int SS = 2;
    localparam int LAT = SS + DB + 1;  // ticks from input change to level change

`ifdef STICKY_SELECT_EN
    localparam bit STICKY = 1'b1;
    localparam logic [NB-1:0] SEL_RST = 5'b00001;
`else
    localparam bit STICKY = 1'b0;
    localparam logic [NB-1:0] SEL_RST = 5'b00000;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, speed_sel;
    int            checks = 0;
    int            errors = 0;
    logic [NB-1:0] sel_hold;

    button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .speed_sel(speed_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hold inputs for n ticks expecting a quiet, constant output set.
    task automatic quiet(input string tag, input int n, input logic [NB-1:0] lvl, input logic [NB-1:0] sel);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_lvl"}, btn_level, lvl);
            chk({tag, "_prs"}, btn_press, 5'b00000);
            chk({tag, "_sel"}, speed_sel, sel);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_lvl", btn_level, 5'b00000);
        chk("rst_prs", btn_press, 5'b00000);
        chk("rst_sel", speed_sel, SEL_RST);
        rst_n = 1'b1;

        // 1. Clean press of button 2
        btn_raw = 5'b00100;
        quiet("s1_wait", LAT - 1, 5'b00000, SEL_RST);
        tick();
        chk("s1_lvl", btn_level, 5'b00100);
        chk("s1_prs", btn_press, 5'b00100);
        tick();
        chk("s1_prs_off", btn_press, 5'b00000);
        chk("s1_sel", speed_sel, 5'b00100);
        quiet("s1_hold", 8, 5'b00100, 5'b00100);

        // 4. Release of button 2
        btn_raw = 5'b00000;
        quiet("s4_wait", LAT - 1, 5'b00100, 5'b00100);
        tick();
        chk("s4_lvl", btn_level, 5'b00000);
        chk("s4_prs", btn_press, 5'b00000);
        tick();
        sel_hold = STICKY ? 5'b00100 : 5'b00000;
        chk("s4_sel", speed_sel, sel_hold);
        chk("s4_prs2", btn_press, 5'b00000);

        // 2. Bounce on button 1 shorter than the debounce window
        for (int c = 0; c < 30; c++) begin
            btn_raw[1] = ((c / 3) % 2) == 0;
            tick();
            chk("s2_lvl", btn_level, 5'b00000);
            chk("s2_prs", btn_press, 5'b00000);
            chk("s2_sel", speed_sel, sel_hold);
        end
        btn_raw = 5'b00000;
        quiet("s2_tail", 12, 5'b00000, sel_hold);

        // 3. Simultaneous press of buttons 1 and 4
        btn_raw = 5'b10010;
        quiet("s3_wait", LAT - 1, 5'b00000, sel_hold);
        tick();
        chk("s3_lvl", btn_level, 5'b10010);
        chk("s3_prs", btn_press, 5'b10010);
        tick();
        chk("s3_prs_off", btn_press, 5'b00000);
        chk("s3_sel", speed_sel, STICKY ? 5'b00010 : 5'b00000);
        btn_raw = 5'b00000;
        for (int i = 0; i < 14; i++) tick();
        chk("s3_rel_lvl", btn_level, 5'b00000);

        // 5. Reset asserted with button 2 in RISE at cnt=5
        btn_raw = 5'b00100;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("s5_rst_lvl", btn_level, 5'b00000);
        chk("s5_rst_prs", btn_press, 5'b00000);
        chk("s5_rst_sel", speed_sel, SEL_RST);
        tick(); tick();
        rst_n = 1'b1;
        quiet("s5_wait", LAT - 1, 5'b00000, SEL_RST);
        tick();
        chk("s5_lvl", btn_level, 5'b00100);
        chk("s5_prs", btn_press, 5'b00100);
        tick();
        chk("s5_sel", speed_sel, 5'b00100);
        btn_raw = 5'b00000;
        for (int i = 0; i < 12; i++) tick();
        chk("s5_rel_lvl", btn_level, 5'b00000);
        chk("s5_rel_sel", speed_sel, STICKY ? 5'b00100 : 5'b00000);

        // 6. Back-to-back: button 0 then button 4
        btn_raw = 5'b00001;
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("s6a_pre", btn_press, 5'b00000);
        tick();
        chk("s6a_prs", btn_press, 5'b00001);
        tick();
        chk("s6a_prs_off", btn_press, 5'b00000);
        chk("s6a_sel", speed_sel, 5'b00001);
        btn_raw = 5'b00000;
        for (int i = 0; i < 12; i++) tick();
        chk("s6a_rel", btn_level, 5'b00000);
        btn_raw = 5'b10000;
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("s6b_pre", btn_press, 5'b00000);
        tick();
        chk("s6b_prs", btn_press, 5'b10000);
        tick();
        chk("s6b_prs_off", btn_press, 5'b00000);
        chk("s6b_sel", speed_sel, 5'b10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
